io_rle_encoder: RTL and testbench

IO_RLE_ENCODER -- requirements
Module: io_rle_encoder

---
 rtl/io_rle_encoder.sv | 244 ++++++++++++++++++++++++
 tb/tb_io_rle_encoder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_rle_encoder.sv
// io_rle_encoder: fetches n*count 16-bit elements from RAM, run-length encodes
// the resulting bit stream into {bit,len[2:0]} nibbles and packs eight nibbles
// per 32-bit output word, MSB nibble first.
// Build option: define IO_ENC_HEADER_EN to prepend the 10-bit {n,count} header.
module io_rle_encoder #(
  parameter int unsigned ADDR_STRIDE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  n,
  input  logic [3:0]  count,
  output logic [63:0] address,
  output logic [1:0]  WR_RD,
  input  logic [63:0] from_ram,
  output logic [31:0] data_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE,
`ifdef IO_ENC_HEADER_EN
    HDR,
`endif
    FETCH,
    WAIT,
    SHIFT,
    FLUSH,
    DRAIN
  } state_t;

  state_t      state_q;
  logic [15:0] elem_q;
  logic [3:0]  bitCnt_q;
  logic [9:0]  elemLeft_q;
  logic        runBit_q;
  logic [2:0]  runLen_q;
  logic [31:0] accum_q;
  logic [2:0]  nibCnt_q;
  logic [63:0] address_q;
  logic        rd_q;
  logic [31:0] dataOut_q;
  logic        outValid_q;
  logic        busy_q;
  logic        done_q;
`ifdef IO_ENC_HEADER_EN
  logic [9:0]  hdr_q;
  logic [3:0]  hdrCnt_q;
`endif

  logic        curBit;
  logic        runBit_d;
  logic [2:0]  runLen_d;
  logic        emit;
  logic [4:0]  shAmt;
  logic [31:0] insWord;
  logic        wordDone;
  logic        bufFree;
  logic        stall;
  logic        consume;
  logic        flushHas;
  logic [31:0] flushWord;
  logic [9:0]  totalElems;
  logic [47:0] unusedRamBits;

  assign unusedRamBits = from_ram[63:16];

  // Select the stream bit presented to the run tracker in the current state
  always_comb begin
    curBit = 1'b0;
`ifdef IO_ENC_HEADER_EN
    if (state_q == HDR) curBit = hdr_q[9];
`endif
    if (state_q == SHIFT) curBit = elem_q[15];
  end

  // Extend the open run, or close it as a nibble when the bit flips or it hits 7
  always_comb begin
    emit     = 1'b0;
    runBit_d = curBit;
    runLen_d = 3'd1;
    if ((runLen_q != 3'd0) && (curBit == runBit_q) && (runLen_q != 3'd7)) begin
      runBit_d = runBit_q;
      runLen_d = runLen_q + 3'd1;
    end else if (runLen_q != 3'd0) begin
      emit = 1'b1;
    end
  end

  // The closed nibble is always the open run; it lands at the next free slot.
  // Padding is implicit because the accumulator starts cleared.
  assign shAmt      = 5'd28 - {nibCnt_q, 2'b00};
  assign insWord    = accum_q | ({28'd0, runBit_q, runLen_q} << shAmt);
  assign wordDone   = emit && (nibCnt_q == 3'd7);
  assign bufFree    = !outValid_q || out_ready;
  assign stall      = wordDone && !bufFree;
  assign flushHas   = (runLen_q != 3'd0) || (nibCnt_q != 3'd0);
  assign flushWord  = (runLen_q != 3'd0) ? insWord : accum_q;
  assign totalElems = 10'(n) * 10'(count);

`ifdef IO_ENC_HEADER_EN
  assign consume = ((state_q == SHIFT) || (state_q == HDR)) && !stall;
`else
  assign consume = (state_q == SHIFT) && !stall;
`endif

  // Main controller: sequencing, RAM reads, run tracking, packing and output buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      elem_q     <= '0;
      bitCnt_q   <= '0;
      elemLeft_q <= '0;
      runBit_q   <= 1'b0;
      runLen_q   <= '0;
      accum_q    <= '0;
      nibCnt_q   <= '0;
      address_q  <= '0;
      rd_q       <= 1'b0;
      dataOut_q  <= '0;
      outValid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef IO_ENC_HEADER_EN
      hdr_q      <= '0;
      hdrCnt_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      rd_q   <= 1'b0;
      if (outValid_q && out_ready) outValid_q <= 1'b0;

      if (consume) begin
        runBit_q <= runBit_d;
        runLen_q <= runLen_d;
        if (wordDone) begin
          dataOut_q  <= insWord;
          outValid_q <= 1'b1;
          accum_q    <= '0;
          nibCnt_q   <= '0;
        end else if (emit) begin
          accum_q  <= insWord;
          nibCnt_q <= nibCnt_q + 3'd1;
        end
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            elemLeft_q <= totalElems;
            address_q  <= '0;
            runBit_q   <= 1'b0;
            runLen_q   <= '0;
            accum_q    <= '0;
            nibCnt_q   <= '0;
`ifdef IO_ENC_HEADER_EN
            hdr_q    <= {n, count};
            hdrCnt_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= HDR;
`else
            if (totalElems == 10'd0) begin
              done_q <= 1'b1;
            end else begin
              busy_q  <= 1'b1;
              rd_q    <= 1'b1;
              state_q <= FETCH;
            end
`endif
          end
        end
`ifdef IO_ENC_HEADER_EN
        HDR: begin
          if (consume) begin
            hdr_q    <= {hdr_q[8:0], 1'b0};
            hdrCnt_q <= hdrCnt_q + 4'd1;
            if (hdrCnt_q == 4'd9) begin
              if (elemLeft_q == 10'd0) begin
                state_q <= FLUSH;
              end else begin
                rd_q    <= 1'b1;
                state_q <= FETCH;
              end
            end
          end
        end
`endif
        FETCH: state_q <= WAIT;
        WAIT: begin
          elem_q     <= from_ram[15:0];
          elemLeft_q <= elemLeft_q - 10'd1;
          bitCnt_q   <= '0;
          address_q  <= address_q + 64'(ADDR_STRIDE);
          state_q    <= SHIFT;
        end
        SHIFT: begin
          if (consume) begin
            elem_q   <= {elem_q[14:0], 1'b0};
            bitCnt_q <= bitCnt_q + 4'd1;
            if (bitCnt_q == 4'd15) begin
              if (elemLeft_q == 10'd0) begin
                state_q <= FLUSH;
              end else begin
                rd_q    <= 1'b1;
                state_q <= FETCH;
              end
            end
          end
        end
        FLUSH: begin
          if (!flushHas) begin
            state_q <= DRAIN;
          end else if (bufFree) begin
            dataOut_q  <= flushWord;
            outValid_q <= 1'b1;
            runLen_q   <= '0;
            accum_q    <= '0;
            nibCnt_q   <= '0;
            state_q    <= DRAIN;
          end
        end
        DRAIN: begin
          if (bufFree) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign address   = address_q;
  assign WR_RD     = {1'b0, rd_q};
  assign data_out  = dataOut_q;
  assign out_valid = outValid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_io_rle_encoder.sv
// tb_io_rle_encoder: table-driven directed vectors for io_rle_encoder plus
// hand-written stall and mid-run reset sequences. Expected words are
// hand-computed for whichever header configuration is being built.
module tb_io_rle_encoder;

  localparam int STRIDE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  n;
  logic [3:0]  count;
  logic [63:0] address;
  logic [1:0]  WR_RD;
  logic [63:0] from_ram = 64'd0;
  logic [31:0] data_out;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  io_rle_encoder #(.ADDR_STRIDE(STRIDE)) dut (
    .clk(clk), .rst(rst), .start(start), .n(n), .count(count),
    .address(address), .WR_RD(WR_RD), .from_ram(from_ram),
    .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]        n;
    logic [3:0]        cnt;
    logic [3:0][15:0]  ram;
    int                nWords;
    logic [2:0][31:0]  words;
    int                lat;
  } vec_t;

  vec_t        vecs[$];
  int          checks = 0;
  int          fails  = 0;
  logic [15:0] mem [16];
  logic [31:0] expWords[$];
  logic [31:0] gotWords[$];
  logic [63:0] gotAddrs[$];
  int          doneCount = 0;
  int          holdErrs  = 0;
  int          wrErrs    = 0;
  logic        pend      = 1'b0;
  logic [15:0] pendData  = 16'd0;
  logic        holdPrev  = 1'b0;
  logic [31:0] heldWord  = 32'd0;

  // RAM model: data appears only in the cycle after the read strobe, upper bits are junk
  always @(negedge clk) begin
    from_ram = pend ? {48'hA5A5_5A5A_C3C3, pendData} : 64'hDEAD_BEEF_DEAD_BEEF;
    pend     = WR_RD[0];
    pendData = mem[address[5:2]];
  end

  // Monitor: log accepted words, read addresses, done pulses and buffer hold violations
  always @(negedge clk) begin
    if (rst) begin
      holdPrev = 1'b0;
    end else begin
      if (out_valid && out_ready) gotWords.push_back(data_out);
      if (WR_RD[0]) gotAddrs.push_back(address);
      if (WR_RD[1]) wrErrs++;
      if (done) doneCount++;
      if (holdPrev && (!out_valid || data_out != heldWord)) holdErrs++;
      holdPrev = out_valid && !out_ready;
      heldWord = data_out;
    end
  end

  // Compare one value and report a failure line if it differs
  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  // Run one transfer and check words, reads, done pulse and handshake behaviour
  task automatic applyStimulus(input string name, input logic [5:0] vn, input logic [3:0] vc,
                               input int stallAt, input int stallLen, input bit spurious,
                               input int wantLatency);
    int cyc;
    bit seen;
    gotWords.delete();
    gotAddrs.delete();
    doneCount = 0;
    holdErrs  = 0;
    wrErrs    = 0;
    @(posedge clk); #1;
    n = vn; count = vc; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 0;
    seen  = 1'b0;
    while (!seen && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        seen = 1'b1;
      end else begin
        @(posedge clk); #1;
        out_ready = !(cyc >= stallAt && cyc < stallAt + stallLen);
        if (spurious) begin
          start = (cyc == 6);
          n     = 6'd63;
          count = 4'hF;
        end
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput({name, "_done_seen"}, 64'(seen), 64'd1);
    checkOutput({name, "_done_pulses"}, 64'(doneCount), 64'd1);
    if (wantLatency >= 0) checkOutput({name, "_done_latency"}, 64'(cyc), 64'(wantLatency));
    checkOutput({name, "_word_count"}, 64'(gotWords.size()), 64'(expWords.size()));
    for (int i = 0; i < expWords.size(); i++)
      checkOutput($sformatf("%s_word%0d", name, i),
                  (i < gotWords.size()) ? 64'(gotWords[i]) : 64'hFFFF_FFFF_FFFF_FFFF,
                  64'(expWords[i]));
    checkOutput({name, "_read_count"}, 64'(gotAddrs.size()), 64'(int'(vn) * int'(vc)));
    for (int k = 0; k < int'(vn) * int'(vc) && k < gotAddrs.size(); k++)
      checkOutput($sformatf("%s_addr%0d", name, k), gotAddrs[k], 64'(STRIDE * k));
    checkOutput({name, "_hold_errs"}, 64'(holdErrs), 64'd0);
    checkOutput({name, "_wr_strobe"}, 64'(wrErrs), 64'd0);
    checkOutput({name, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  // Append one directed vector to the table
  task automatic addVec(input logic [5:0] vn, input logic [3:0] vc,
                        input logic [15:0] r0, input logic [15:0] r1,
                        input logic [15:0] r2, input logic [15:0] r3,
                        input int nw, input logic [31:0] w0, input logic [31:0] w1,
                        input logic [31:0] w2, input int lat);
    vec_t v;
    v.n      = vn;
    v.cnt    = vc;
    v.ram    = {r3, r2, r1, r0};
    v.nWords = nw;
    v.words  = {w2, w1, w0};
    v.lat    = lat;
    vecs.push_back(v);
  endtask

  // Hard stop so the bench can never hang
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset, vector table, stall run, mid-run reset
  initial begin
    rst = 1'b1; start = 1'b0; n = '0; count = '0; out_ready = 1'b0;
    for (int k = 0; k < 16; k++) mem[k] = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_address",   address,         64'd0);
    checkOutput("reset_wr_rd",     64'(WR_RD),      64'd0);
    checkOutput("reset_data_out",  64'(data_out),   64'd0);
    checkOutput("reset_out_valid", 64'(out_valid),  64'd0);
    checkOutput("reset_busy",      64'(busy),       64'd0);
    checkOutput("reset_done",      64'(done),       64'd0);
    @(posedge clk); #1 rst = 1'b0;

`ifdef IO_ENC_HEADER_EN
    addVec(1, 1, 16'hFFFF, 0, 0, 0, 1, 32'h593FFB00, 0, 0, -1);
    addVec(1, 1, 16'h0000, 0, 0, 0, 1, 32'h59397720, 0, 0, -1);
    addVec(1, 1, 16'hAAAA, 0, 0, 0, 3, 32'h593A1919, 32'h19191919, 32'h19100000, -1);
    addVec(2, 1, 16'hFFFF, 16'hFFFF, 0, 0, 1, 32'h494FFFFD, 0, 0, -1);
    addVec(1, 2, 16'h00FF, 16'hF000, 0, 0, 2, 32'h592972FD, 32'h75000000, 0, -1);
    addVec(0, 3, 0, 0, 0, 0, 1, 32'h71A00000, 0, 0, -1);
    addVec(5, 0, 0, 0, 0, 0, 1, 32'h39194000, 0, 0, -1);
    addVec(2, 2, 16'h8001, 16'h7FFE, 16'h0F0F, 16'hF0F0, 3,
           32'h49391977, 32'h91FF5C4F, 32'h94C40000, -1);
`else
    addVec(1, 1, 16'hFFFF, 0, 0, 0, 1, 32'hFFA00000, 0, 0, -1);
    addVec(1, 1, 16'h0000, 0, 0, 0, 1, 32'h77200000, 0, 0, -1);
    addVec(1, 1, 16'hAAAA, 0, 0, 0, 2, 32'h91919191, 32'h91919191, 0, -1);
    addVec(2, 1, 16'hFFFF, 16'hFFFF, 0, 0, 1, 32'hFFFFC000, 0, 0, -1);
    addVec(1, 2, 16'h00FF, 16'hF000, 0, 0, 1, 32'h71FD7500, 0, 0, -1);
    addVec(0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    addVec(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    addVec(2, 2, 16'h8001, 16'h7FFE, 16'h0F0F, 16'hF0F0, 2,
           32'h97791FF5, 32'hC4F94C40, 0, -1);
`endif

    foreach (vecs[i]) begin
      for (int k = 0; k < 16; k++) mem[k] = (k < 4) ? vecs[i].ram[k] : 16'h0;
      expWords.delete();
      for (int k = 0; k < vecs[i].nWords; k++) expWords.push_back(vecs[i].words[k]);
      applyStimulus($sformatf("vec%0d", i), vecs[i].n, vecs[i].cnt, 0, 0, 1'b0, vecs[i].lat);
    end

    // Back-pressure for 20 cycles plus an ignored start while busy
    for (int k = 0; k < 16; k++) mem[k] = 16'hAAAA;
    expWords.delete();
`ifdef IO_ENC_HEADER_EN
    expWords.push_back(32'h49391919);
    for (int k = 0; k < 7; k++) expWords.push_back(32'h19191919);
    expWords.push_back(32'h19191000);
`else
    for (int k = 0; k < 8; k++) expWords.push_back(32'h91919191);
`endif
    applyStimulus("stall", 6'd2, 4'd2, 20, 20, 1'b1, -1);

    // Reset while shifting payload bits with a word held in the buffer
    @(posedge clk); #1;
    n = 6'd2; count = 4'd2; out_ready = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (13) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_busy",      64'(busy),      64'd0);
    checkOutput("midrst_wr_rd",     64'(WR_RD),     64'd0);
    checkOutput("midrst_done",      64'(done),      64'd0);
    checkOutput("midrst_data_out",  64'(data_out),  64'd0);
    @(posedge clk); #1 rst = 1'b0;
    doneCount = 0;
    repeat (30) @(negedge clk);
    checkOutput("midrst_no_done", 64'(doneCount), 64'd0);

    mem[0] = 16'hFFFF;
    expWords.delete();
`ifdef IO_ENC_HEADER_EN
    expWords.push_back(32'h593FFB00);
`else
    expWords.push_back(32'hFFA00000);
`endif
    applyStimulus("after_rst", 6'd1, 4'd1, 0, 0, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
